// File: rtl/fpmul_pipe.sv
// Four-stage pipelined IEEE-754 multiplier, round-to-nearest-even, valid/ready on both sides.
// Define FPMUL_FTZ_EN to flush subnormal inputs and tiny results to signed zero.
module fpmul_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   z,
    output logic [TAG_W-1:0]       out_tag,
    output logic [3:0]             flags
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int XW  = EXP_W + 2;
    localparam int SW  = MAN_W + 1;
    localparam int PW  = 2 * SW;
    localparam int LZW = $clog2(SW + 1);
    localparam logic signed [XW-1:0] BIAS_X = XW'(2 ** (EXP_W - 1) - 1);
    localparam logic signed [XW-1:0] ONE_X  = XW'(1);
    localparam logic signed [XW-1:0] EMAX_X = XW'(2 ** EXP_W - 1);
    localparam logic signed [XW-1:0] SH_MAX = XW'(MAN_W + 3);
    localparam logic [W-1:0] QNAN = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

    function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
        lzc = LZW'(SW);
        for (int i = 0; i < SW; i++) begin
            if (v[i]) lzc = LZW'(SW - 1 - i);
        end
    endfunction

    logic advance;
    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    // Special-case result is resolved in S1 and carried alongside the datapath.
    logic                   s1_vld_q, s1_spec_q, s1_sgn_q, s1_spec_d;
    logic [W-1:0]           s1_z_q, s1_z_d;
    logic [3:0]             s1_fl_q, s1_fl_d;
    logic [TAG_W-1:0]       s1_tag_q;
    logic signed [XW-1:0]   s1_ea_q, s1_eb_q;
    logic [SW-1:0]          s1_ma_q, s1_mb_q;

    logic                   s2_vld_q, s2_spec_q, s2_sgn_q;
    logic [W-1:0]           s2_z_q;
    logic [3:0]             s2_fl_q;
    logic [TAG_W-1:0]       s2_tag_q;
    logic signed [XW-1:0]   s2_exp_q, s2_exp_d;
    logic [PW-1:0]          s2_prod_q, s2_prod_d;

    logic                   s3_vld_q, s3_spec_q, s3_sgn_q, s3_inx_q, s3_inx_d;
    logic [W-1:0]           s3_z_q;
    logic [3:0]             s3_fl_q;
    logic [TAG_W-1:0]       s3_tag_q;
    logic signed [XW-1:0]   s3_exp_q, s3_exp_d;
    logic [MAN_W-1:0]       s3_frac_q, s3_frac_d;

    logic [W-1:0]           z_d;
    logic [3:0]             fl_d;

    // S1: unpack and classify
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, sgn;
    assign a_exp  = a[W-2 -: EXP_W];
    assign b_exp  = b[W-2 -: EXP_W];
    assign a_frac = a[MAN_W-1:0];
    assign b_frac = b[MAN_W-1:0];
    assign sgn    = a[W-1] ^ b[W-1];

    always_comb begin
`ifdef FPMUL_FTZ_EN
        a_zero = (a_exp == '0);
        b_zero = (b_exp == '0);
`else
        a_zero = (a_exp == '0) && (a_frac == '0);
        b_zero = (b_exp == '0) && (b_frac == '0);
`endif
        a_inf  = (&a_exp) && (a_frac == '0);
        b_inf  = (&b_exp) && (b_frac == '0);
        a_nan  = (&a_exp) && (a_frac != '0);
        b_nan  = (&b_exp) && (b_frac != '0);
        a_snan = a_nan && !a_frac[MAN_W-1];
        b_snan = b_nan && !b_frac[MAN_W-1];
        s1_spec_d = 1'b1;
        s1_fl_d   = 4'b0000;
        s1_z_d    = QNAN;
        if (a_nan || b_nan) begin
            s1_fl_d[3] = a_snan | b_snan;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            s1_fl_d[3] = 1'b1;
        end else if (a_inf || b_inf) begin
            s1_z_d = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero || b_zero) begin
            s1_z_d = {sgn, {(W - 1){1'b0}}};
        end else begin
            s1_spec_d = 1'b0;
        end
    end

    // S2: normalise subnormal significands, sum exponents, multiply
    logic [LZW-1:0] lza, lzb;
    logic [SW-1:0]  na, nb;
    always_comb begin
        lza       = lzc(s1_ma_q);
        lzb       = lzc(s1_mb_q);
        na        = s1_ma_q << lza;
        nb        = s1_mb_q << lzb;
        s2_prod_d = PW'(na) * PW'(nb);
        s2_exp_d  = s1_ea_q - XW'(lza) + s1_eb_q - XW'(lzb) - BIAS_X;
    end

    // S3: normalise, denormalise tiny results into sticky, round to nearest even
    logic                 top, stk, rnd_up, lost;
    logic [PW-1:0]        pn, shifted;
    logic signed [XW-1:0] e3, diff;
    logic [XW-1:0]        sh;
    logic [MAN_W+1:0]     mant;
    always_comb begin
        top  = s2_prod_q[PW-1];
        pn   = top ? s2_prod_q : {s2_prod_q[PW-2:0], 1'b0};
        e3   = s2_exp_q + XW'(top);
        diff = ONE_X - e3;
        sh   = '0;
        if (e3 < ONE_X) begin
            sh = (diff > SH_MAX) ? SH_MAX : diff;
            e3 = ONE_X;
        end
        shifted  = pn >> sh;
        lost     = |(pn & ~({PW{1'b1}} << sh));
        stk      = (|shifted[MAN_W-2:0]) | lost;
        rnd_up   = shifted[MAN_W] & (shifted[MAN_W-1] | stk | shifted[MAN_W+1]);
        mant     = {1'b0, shifted[PW-1:MAN_W+1]} + {{(MAN_W + 1){1'b0}}, rnd_up};
        s3_inx_d = shifted[MAN_W] | shifted[MAN_W-1] | stk;
        if (mant[MAN_W+1]) begin
            s3_exp_d  = e3 + ONE_X;
            s3_frac_d = '0;
        end else begin
            // Hidden bit clear means the result stayed subnormal (exponent field 0).
            s3_exp_d  = mant[MAN_W] ? e3 : '0;
            s3_frac_d = mant[MAN_W-1:0];
        end
    end

    // S4: pack, overflow and underflow
    always_comb begin
        z_d  = {s3_sgn_q, s3_exp_q[EXP_W-1:0], s3_frac_q};
        fl_d = {3'b000, s3_inx_q};
        if (s3_spec_q) begin
            z_d  = s3_z_q;
            fl_d = s3_fl_q;
        end else if (s3_exp_q >= EMAX_X) begin
            z_d  = {s3_sgn_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            fl_d = 4'b0101;
        end else if (s3_exp_q == '0) begin
`ifdef FPMUL_FTZ_EN
            z_d  = {s3_sgn_q, {(W - 1){1'b0}}};
            fl_d = 4'b0011;
`else
            fl_d = {2'b00, s3_inx_q, s3_inx_q};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s3_vld_q  <= 1'b0;
            out_valid <= 1'b0;
            z         <= '0;
            out_tag   <= '0;
            flags     <= '0;
        end else if (advance) begin
            s1_vld_q  <= in_valid;
            s2_vld_q  <= s1_vld_q;
            s3_vld_q  <= s2_vld_q;
            out_valid <= s3_vld_q;
            if (s3_vld_q) begin
                z       <= z_d;
                out_tag <= s3_tag_q;
                flags   <= fl_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            s1_spec_q <= s1_spec_d;
            s1_sgn_q  <= sgn;
            s1_z_q    <= s1_z_d;
            s1_fl_q   <= s1_fl_d;
            s1_tag_q  <= in_tag;
            s1_ea_q   <= (a_exp == '0) ? ONE_X : XW'(a_exp);
            s1_eb_q   <= (b_exp == '0) ? ONE_X : XW'(b_exp);
            s1_ma_q   <= {a_exp != '0, a_frac};
            s1_mb_q   <= {b_exp != '0, b_frac};
            s2_spec_q <= s1_spec_q;
            s2_sgn_q  <= s1_sgn_q;
            s2_z_q    <= s1_z_q;
            s2_fl_q   <= s1_fl_q;
            s2_tag_q  <= s1_tag_q;
            s2_exp_q  <= s2_exp_d;
            s2_prod_q <= s2_prod_d;
            s3_spec_q <= s2_spec_q;
            s3_sgn_q  <= s2_sgn_q;
            s3_z_q    <= s2_z_q;
            s3_fl_q   <= s2_fl_q;
            s3_tag_q  <= s2_tag_q;
            s3_exp_q  <= s3_exp_d;
            s3_frac_q <= s3_frac_d;
            s3_inx_q  <= s3_inx_d;
        end
    end

endmodule
